// File: rtl/patch_pkg.sv
// Shared definitions for the patch controller: FSM states, config field layout
// and trigger counter width.
package patch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } patch_state_t;

    localparam int TRIG_CNT_W = 8;

    // Config fields are packed LSB upward; each offset depends only on the tap width.
    function automatic int OVR_MASK_LSB(input int width);
        return 0 * width;
    endfunction

    function automatic int OVR_VAL_LSB(input int width);
        return width;
    endfunction

    function automatic int TRIG_MASK_LSB(input int width);
        return 2 * width;
    endfunction

    function automatic int TRIG_VAL_LSB(input int width);
        return 3 * width;
    endfunction

    function automatic int HOLD_LSB(input int width);
        return 4 * width;
    endfunction

endpackage

// File: rtl/patch_cfg_shifter.sv
// Serial config loader: a right-shifting shadow register that is copied
// into the active config on a commit pulse.
module patch_cfg_shifter #(
    parameter int CFG_BITS = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_shift,
    input  logic                cfg_bit,
    input  logic                cfg_commit,
    output logic [CFG_BITS-1:0] active_cfg
);

    logic [CFG_BITS-1:0] shadow_cfg;

    // The commit reads the shadow value from before any same-cycle shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cfg <= '0;
            active_cfg <= '0;
        end else begin
            if (cfg_shift)
                shadow_cfg <= {cfg_bit, shadow_cfg[CFG_BITS-1:1]};
            if (cfg_commit)
                active_cfg <= shadow_cfg;
        end
    end

endmodule

// File: rtl/patch_signal_controller.sv
// Patch controller: passes tapped signals through, and on a programmed trigger
// forces selected bits for a fixed or unbounded number of cycles.
module patch_signal_controller
    import patch_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      control_port_in,
    output logic [WIDTH-1:0]      control_port_out,
    input  logic                  patch_en,
    input  logic                  cfg_shift,
    input  logic                  cfg_bit,
    input  logic                  cfg_commit,
    output logic                  patch_active,
    output logic [TRIG_CNT_W-1:0] trig_count
);

    localparam int CFG_BITS = 4 * WIDTH + CNT_W;

    logic [CFG_BITS-1:0] active_cfg;
    logic [WIDTH-1:0]    ovr_mask;
    logic [WIDTH-1:0]    ovr_val;
    logic [WIDTH-1:0]    trig_mask;
    logic [WIDTH-1:0]    trig_val;
    logic [CNT_W-1:0]    hold;

    patch_state_t     state;
    patch_state_t     next_state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             trig_hit;
    logic             trig_inc;

    patch_cfg_shifter #(
        .CFG_BITS (CFG_BITS)
    ) u_cfg_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_shift  (cfg_shift),
        .cfg_bit    (cfg_bit),
        .cfg_commit (cfg_commit),
        .active_cfg (active_cfg)
    );

    assign ovr_mask  = active_cfg[OVR_MASK_LSB(WIDTH)  +: WIDTH];
    assign ovr_val   = active_cfg[OVR_VAL_LSB(WIDTH)   +: WIDTH];
    assign trig_mask = active_cfg[TRIG_MASK_LSB(WIDTH) +: WIDTH];
    assign trig_val  = active_cfg[TRIG_VAL_LSB(WIDTH)  +: WIDTH];
    assign hold      = active_cfg[HOLD_LSB(WIDTH)      +: CNT_W];

    assign trig_hit = ((control_port_in ^ trig_val) & trig_mask) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            trig_count <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= hold_cnt_next;
            if (trig_inc && (trig_count != '1))
                trig_count <= trig_count + 1'b1;
        end
    end

    // Disable beats commit beats normal sequencing; a zero hold count marks a sticky burst.
    always_comb begin
        next_state    = state;
        hold_cnt_next = hold_cnt;
        trig_inc      = 1'b0;
        if (!patch_en) begin
            next_state    = IDLE;
            hold_cnt_next = '0;
        end else if (cfg_commit) begin
            next_state    = ARMED;
            hold_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = ARMED;
                end
                ARMED: begin
                    if (trig_hit) begin
                        next_state    = ACTIVE;
                        hold_cnt_next = hold;
                        trig_inc      = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (hold_cnt == CNT_W'(1)) begin
                        next_state    = ARMED;
                        hold_cnt_next = '0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt_next = hold_cnt - 1'b1;
                    end
                end
                default: begin
                    next_state    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    assign patch_active = (state == ACTIVE);

    always_comb begin
        control_port_out = control_port_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (patch_active && ovr_mask[i])
                control_port_out[i] = ovr_val[i];
        end
    end

endmodule

// File: tb/tb_patch_signal_controller.sv
// Randomized self-checking bench for patch_signal_controller against a
// behavioural burst model (remaining override cycles, -1 meaning unbounded).
module tb_patch_signal_controller;

    localparam int WIDTH    = 4;
    localparam int CNT_W    = 4;
    localparam int CFG_BITS = 4 * WIDTH + CNT_W;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] control_port_in;
    logic [WIDTH-1:0] control_port_out;
    logic             patch_en;
    logic             cfg_shift;
    logic             cfg_bit;
    logic             cfg_commit;
    logic             patch_active;
    logic [7:0]       trig_count;

    int assertions;
    int failures;

    logic [CFG_BITS-1:0] m_shadow;
    logic [CFG_BITS-1:0] m_cfg;
    logic                m_enabled;
    int                  m_left;
    int                  m_count;

    patch_signal_controller #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .control_port_in  (control_port_in),
        .control_port_out (control_port_out),
        .patch_en         (patch_en),
        .cfg_shift        (cfg_shift),
        .cfg_bit          (cfg_bit),
        .cfg_commit       (cfg_commit),
        .patch_active     (patch_active),
        .trig_count       (trig_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_shadow  = '0;
        m_cfg     = '0;
        m_enabled = 1'b0;
        m_left    = 0;
        m_count   = 0;
    endtask

    function automatic logic [WIDTH-1:0] modelOut(input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] om;
        logic [WIDTH-1:0] ov;
        om = m_cfg[3:0];
        ov = m_cfg[7:4];
        if (m_enabled && m_left != 0)
            return (din & ~om) | (ov & om);
        return din;
    endfunction

    task automatic compareAll(input string tag);
        checkOutput({tag, ".out"}, 32'(control_port_out), 32'(modelOut(control_port_in)));
        checkOutput({tag, ".active"}, 32'(patch_active), 32'(m_enabled && m_left != 0));
        checkOutput({tag, ".count"}, 32'(trig_count), 32'(m_count));
    endtask

    // One clock edge of the reference model, using the config active before the edge.
    task automatic modelStep(input logic en, input logic sh, input logic b, input logic cm,
                             input logic [WIDTH-1:0] din);
        logic [WIDTH-1:0] tm;
        logic [WIDTH-1:0] tv;
        int               hold;
        logic             match;
        tm    = m_cfg[11:8];
        tv    = m_cfg[15:12];
        hold  = int'(m_cfg[19:16]);
        match = ((din ^ tv) & tm) == 0;
        if (!en) begin
            m_enabled = 1'b0;
            m_left    = 0;
        end else if (cm) begin
            m_enabled = 1'b1;
            m_left    = 0;
        end else if (!m_enabled) begin
            m_enabled = 1'b1;
        end else if (m_left == 0) begin
            if (match) begin
                m_left = (hold == 0) ? -1 : hold;
                if (m_count < 255)
                    m_count++;
            end
        end else if (m_left > 0) begin
            m_left--;
        end
        if (cm)
            m_cfg = m_shadow;
        if (sh)
            m_shadow = {b, m_shadow[CFG_BITS-1:1]};
    endtask

    task automatic applyStimulus(input logic en, input logic sh, input logic b, input logic cm,
                                 input logic [WIDTH-1:0] din);
        @(negedge clk);
        patch_en        = en;
        cfg_shift       = sh;
        cfg_bit         = b;
        cfg_commit      = cm;
        control_port_in = din;
        #1;
        compareAll("cycle");
        @(posedge clk);
        modelStep(en, sh, b, cm, din);
    endtask

    task automatic shiftConfig(input logic [3:0] om, input logic [3:0] ov, input logic [3:0] tm,
                               input logic [3:0] tv, input logic [3:0] hold, input logic en);
        logic [CFG_BITS-1:0] word;
        word = {hold, tv, tm, ov, om};
        for (int i = 0; i < CFG_BITS; i++)
            applyStimulus(en, 1'b1, word[i], 1'b0, 4'($urandom));
    endtask

    task automatic commitConfig(input logic en);
        applyStimulus(en, 1'b0, 1'b0, 1'b1, 4'($urandom));
    endtask

    // Reset asserted between edges; output must fall back to pass-through at once.
    task automatic asyncReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("rst");
        control_port_in = 4'($urandom);
        #1;
        compareAll("rst_in");
        @(negedge clk);
        patch_en   = 1'b0;
        cfg_shift  = 1'b0;
        cfg_commit = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        modelStep(1'b0, 1'b0, 1'b0, 1'b0, control_port_in);
    endtask

    initial begin
        assertions      = 0;
        failures        = 0;
        rst_n           = 1'b0;
        patch_en        = 1'b0;
        cfg_shift       = 1'b0;
        cfg_bit         = 1'b0;
        cfg_commit      = 1'b0;
        control_port_in = 4'hA;
        modelReset();
        #2;
        compareAll("reset");
        checkOutput("reset.passthru", 32'(control_port_out), 32'h0000000A);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelStep(1'b0, 1'b0, 1'b0, 1'b0, control_port_in);

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));

        // Fixed three-cycle burst on bit0 match, forcing bit1 low.
        shiftConfig(4'h2, 4'h0, 4'h1, 4'h1, 4'd3, 1'b0);
        commitConfig(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        checkOutput("burst.count", 32'(trig_count), 32'd1);

        // Sticky burst, then drop the enable.
        shiftConfig(4'h2, 4'h0, 4'h1, 4'h1, 4'd0, 1'b0);
        commitConfig(1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
        checkOutput("sticky.out", 32'(control_port_out), 32'h1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h3);

        // Always-match with hold of one alternates ACTIVE and ARMED.
        shiftConfig(4'h5, 4'hA, 4'h0, 4'h0, 4'd1, 1'b0);
        commitConfig(1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));

        // Commit mid-burst aborts it; the new config then re-triggers.
        shiftConfig(4'h2, 4'h0, 4'h1, 4'h1, 4'd8, 1'b0);
        commitConfig(1'b0);
        shiftConfig(4'hF, 4'hF, 4'h1, 4'h1, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);

        // Shift and commit together: commit must take the pre-shift shadow.
        shiftConfig(4'hC, 4'h4, 4'h0, 4'h0, 4'd2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));

        // Counter saturation at 255.
        shiftConfig(4'h5, 4'hA, 4'h0, 4'h0, 4'd1, 1'b0);
        commitConfig(1'b0);
        for (int i = 0; i < 560; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));
        checkOutput("sat.count", 32'(trig_count), 32'd255);

        // Async reset during a sticky burst.
        shiftConfig(4'hF, 4'h6, 4'h0, 4'h0, 4'd0, 1'b0);
        commitConfig(1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));
        asyncReset();
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));

        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
                          $urandom_range(0, 29) == 0, 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
